// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank: mode encoding and counter ceiling.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Highest count value; keeping it one below all-ones lets duty = all-ones stay high forever.
  function automatic int unsigned pwm_top(input int unsigned width);
    return (32'd1 << width) - 32'd2;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (sawtooth) or center (triangle) sweep, with mode
// latched only at the period boundary so a period never changes shape mid-way.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             center,
  output logic [WIDTH-1:0] count,
  output logic             boundary,
  output logic             period_start
);

  localparam int unsigned    TOP_I = pwm_top(WIDTH);
  localparam logic [WIDTH-1:0] TOP = TOP_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pwm_mode_e        mode;
  logic             dir_up;
  logic             dir_nxt;
  logic             wrap;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    wrap      = 1'b0;
    count_nxt = count + 1'b1;
    dir_nxt   = dir_up;
    if (mode == MODE_EDGE) begin
      wrap = (count == TOP);
    end else if (dir_up) begin
      if (count == TOP) begin
        count_nxt = count - 1'b1;
        dir_nxt   = 1'b0;
      end
    end else begin
      count_nxt = count - 1'b1;
      wrap      = (count == ONE);
    end
    // Every wrap restarts upward, which also covers a mode switch.
    if (wrap) begin
      count_nxt = '0;
      dir_nxt   = 1'b1;
    end
  end

  assign boundary     = enable & wrap;
  assign period_start = enable & (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      dir_up <= 1'b1;
      mode   <= MODE_EDGE;
    end else if (enable) begin
      count  <= count_nxt;
      dir_up <= dir_nxt;
      if (wrap) mode <= pwm_mode_e'(center);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one timebase; duty writes land in a shadow
// register and are applied to all channels together at the period boundary.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enable,
  input  logic                                              center,
  input  logic                                              wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
  input  logic [WIDTH-1:0]                                  wr_data,
  output logic [CHANNELS-1:0]                               pwm_out,
  output logic [CHANNELS-1:0]                               pending,
  output logic                                              period_start
);

  localparam int CW = $bits(wr_chan);

  logic [WIDTH-1:0] count;
  logic             boundary;

  pwm_timebase #(.WIDTH(WIDTH)) u_tb (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .center       (center),
    .count        (count),
    .boundary     (boundary),
    .period_start (period_start)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic             pend_q;
    logic             out_q;
    logic             hit;

    // Out-of-range channel numbers match no index and are dropped here.
    assign hit = wr_en & (wr_chan == CW'(i));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow <= '0;
        active <= '0;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        if (hit) shadow <= wr_data;
        // A write coinciding with a boundary keeps pending: it misses this apply.
        if (hit)           pend_q <= 1'b1;
        else if (boundary) pend_q <= 1'b0;
        if (boundary) active <= shadow;
        if (enable)   out_q  <= (count < active);
      end
    end

    assign pwm_out[i] = out_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Randomized scoreboard bench for pwm_bank against a phase-based reference model.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int CW  = 2;
  localparam int TOP = 254;

  logic          clk = 1'b0;
  logic          reset, enable, center, wr_en;
  logic [CW-1:0] wr_chan;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm_out, pending;
  logic          period_start;

  pwm_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .center(center),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .pwm_out(pwm_out), .pending(pending), .period_start(period_start)
  );

  // Small instance where wr_chan can actually name a channel that does not exist.
  logic       r3, en3, c3, we3, ps3, done3;
  logic [1:0] wc3;
  logic [3:0] wd3;
  logic [2:0] po3, pe3;

  pwm_bank #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(r3), .enable(en3), .center(c3),
    .wr_en(we3), .wr_chan(wc3), .wr_data(wd3),
    .pwm_out(po3), .pending(pe3), .period_start(ps3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] out;
    logic [CH-1:0] pend;
    logic          ps;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: phase p within the period, value derived arithmetically.
  int            p, last_phase, obs_phase, cur_ctr;
  bit            m;
  int            act_m[CH], sh_m[CH];
  bit            pend_m[CH], out_m[CH];
  logic [CH-1:0] obs;
  bit            obs_ps;
  int            m_hi[CH];
  int            m_len;
  bit            m_sym;

  function automatic int val(input int ph, input bit md);
    if (!md) return ph;
    return (ph <= TOP) ? ph : 2 * TOP - ph;
  endfunction

  function automatic int plen(input bit md);
    return md ? 2 * TOP : TOP + 1;
  endfunction

  task automatic cyc(input bit en, input bit ctr, input bit we, input int wc, input int wd, input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    obs       = pwm_out;
    obs_phase = last_phase;
    enable = en; center = ctr; wr_en = we; reset = rst;
    wr_chan = wc[CW-1:0]; wr_data = wd[W-1:0];
    if (rst) begin
      p = 0; m = 0; last_phase = -1;
      for (int i = 0; i < CH; i++) begin
        act_m[i] = 0; sh_m[i] = 0; pend_m[i] = 0; out_m[i] = 0;
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.out[i]  = out_m[i];
      e.pend[i] = pend_m[i];
    end
    e.ps = en && (val(p, m) == 0);
    sb.push_back(e);
    if (!rst) begin
      last_phase = en ? p : -1;
      if (en) begin
        for (int i = 0; i < CH; i++) out_m[i] = (val(p, m) < act_m[i]);
        if (p == plen(m) - 1) begin
          for (int i = 0; i < CH; i++) begin
            act_m[i]  = sh_m[i];
            pend_m[i] = 0;
          end
          m = ctr;
          p = 0;
        end else begin
          p++;
        end
      end
      if (we && wc < CH) begin
        sh_m[wc]   = wd;
        pend_m[wc] = 1;
      end
    end
    #2 obs_ps = period_start;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, cur_ctr[0], 0, 0, 0, 0);
  endtask

  task automatic until_mode(input bit md);
    int g = 0;
    cur_ctr = md;
    while (m != md && g < 1200) begin idle(1); g++; end
  endtask

  // Collect the DUT outputs for one full period, aligned by the phase each output reflects.
  task automatic measure();
    bit seen[0:1023];
    bit started = 0;
    int g = 0;
    int L = plen(m);
    for (int i = 0; i < CH; i++) m_hi[i] = 0;
    m_len = 0;
    m_sym = 1;
    while (g < 3000) begin
      idle(1);
      g++;
      if (obs_phase == 0) started = 1;
      if (started && obs_phase >= 0) begin
        seen[obs_phase] = obs[0];
        for (int i = 0; i < CH; i++) m_hi[i] += int'(obs[i]);
        m_len++;
        if (obs_phase == L - 1) break;
      end
    end
    for (int k = 1; k < L; k++) if (seen[k] != seen[L - k]) m_sym = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pwm_out", int'(pwm_out), int'(e.out));
      chk("pending", int'(pending), int'(e.pend));
      chk("period_start", int'(period_start), int'(e.ps));
    end
  end

  initial begin
    r3 = 1; en3 = 0; c3 = 0; we3 = 0; wc3 = 0; wd3 = 0; done3 = 0;
    repeat (2) @(posedge clk);
    #1 r3 = 0; en3 = 1; we3 = 1; wc3 = 2'd3; wd3 = 4'd15;
    @(posedge clk); #1 we3 = 0;
    @(negedge clk);
    chk("oob_pending", int'(pe3), 0);
    repeat (40) @(negedge clk);
    chk("oob_pwm", int'(po3), 0);
    @(posedge clk); #1 we3 = 1; wc3 = 2'd2; wd3 = 4'd15;
    @(posedge clk); #1 we3 = 0;
    @(negedge clk);
    chk("inrange_pending", int'(pe3), 4);
    repeat (40) @(negedge clk);
    chk("inrange_pwm", int'(po3), 4);
    done3 = 1;
  end

  initial begin
    int n, g;
    reset = 1; enable = 0; center = 0; wr_en = 0; wr_chan = '0; wr_data = '0;
    cur_ctr = 0; last_phase = -1; p = 0; m = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset in the middle of a running period.
    cyc(1, 0, 1, 0, 200, 0);
    idle(300);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("ps_after_reset", int'(obs_ps), 1);
    chk("pwm_after_reset", int'(pwm_out), 0);
    chk("pend_after_reset", int'(pending), 0);

    // Edge mode, half duty.
    cyc(1, 0, 1, 0, 128, 0);
    measure();
    chk("edge128_hi", m_hi[0], 128);
    chk("edge128_len", m_len, 255);

    // Duty extremes across three boundaries.
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 2, 255, 0);
    for (int k = 0; k < 3; k++) begin
      measure();
      chk("duty0_hi", m_hi[1], 0);
      chk("duty255_hi", m_hi[2], 255);
    end

    // Write landing exactly on the boundary edge.
    cyc(1, 0, 1, 3, 50, 0);
    measure();
    g = 0;
    while (p != plen(m) - 1 && g < 1200) begin idle(1); g++; end
    cyc(1, 0, 1, 3, 10, 0);
    idle(1);
    chk("bwrite_pending", int'(pending[3]), 1);
    measure();
    chk("bwrite_old_hi", m_hi[3], 50);
    measure();
    chk("bwrite_new_hi", m_hi[3], 10);

    // Center-aligned mode.
    cyc(1, 1, 1, 0, 64, 0);
    until_mode(1);
    measure();
    chk("center64_hi", m_hi[0], 127);
    chk("center64_len", m_len, 508);
    chk("center64_sym", int'(m_sym), 1);
    until_mode(0);

    // Freeze for 20 cycles mid-period.
    g = 0;
    while (!obs_ps && g < 600) begin idle(1); g++; end
    n = 0;
    idle(100); n += 100;
    repeat (20) begin cyc(0, 0, 0, 0, 0, 0); n++; end
    idle(1); n++;
    while (!obs_ps && n < 1000) begin idle(1); n++; end
    chk("freeze_period", n, 275);

    // Randomized traffic, checked cycle by cycle through the scoreboard.
    repeat (4000) begin
      bit en, we, rst;
      int wc, wd;
      en  = ($urandom_range(0, 9) != 0);
      we  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      wc  = $urandom_range(0, CH - 1);
      case ($urandom_range(0, 3))
        0:       wd = 0;
        1:       wd = 255;
        default: wd = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 799) == 0) cur_ctr = 1 - cur_ctr;
      cyc(en, cur_ctr[0], we, wc, wd, rst);
    end

    repeat (2) @(negedge clk);
    g = 0;
    while (!done3 && g < 200) begin @(posedge clk); g++; end
    if (!done3) chk("dut3_done", 0, 1);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
